// File: rtl/segre_history_file_if.sv
// ---------------------------------------------------------------------------
// segre_history_file_if
// Bundle between the ID/pipeline side and the history file.
//   alloc_*   : ID allocates one entry per writing/store instruction
//   cmpl_*    : per-port completion strobes (0=EX, 1=MEM, 2=RVM5)
//   full/empty: occupancy status back to ID
//   retire_*  : in-order retirement of the head entry
//   rb_*      : register-file restore writes during rollback
//   recover/exc: front-end squash and exception report
// Modports: master = ID/pipelines, slave = history file.
// ---------------------------------------------------------------------------
interface segre_history_file_if #(
  parameter int HF_PTR    = 4,
  parameter int NUM_CMPL  = 3,
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5
);
  logic                         alloc_i;
  logic [HF_PTR-1:0]            alloc_id_i;
  logic                         alloc_we_i;
  logic [REG_SIZE-1:0]          alloc_waddr_i;
  logic [WORD_SIZE-1:0]         alloc_old_i;
  logic                         alloc_store_i;
  logic [NUM_CMPL-1:0]          cmpl_valid_i;
  logic [NUM_CMPL*HF_PTR-1:0]   cmpl_id_i;
  logic [NUM_CMPL-1:0]          cmpl_exc_i;
  logic                         full_o;
  logic                         empty_o;
  logic                         retire_valid_o;
  logic [HF_PTR-1:0]            retire_id_o;
  logic                         retire_store_o;
  logic                         rb_we_o;
  logic [REG_SIZE-1:0]          rb_waddr_o;
  logic [WORD_SIZE-1:0]         rb_data_o;
  logic                         recover_o;
  logic                         exc_o;
  logic [HF_PTR-1:0]            exc_id_o;

  modport master (
    output alloc_i, alloc_id_i, alloc_we_i, alloc_waddr_i, alloc_old_i, alloc_store_i,
    output cmpl_valid_i, cmpl_id_i, cmpl_exc_i,
    input  full_o, empty_o, retire_valid_o, retire_id_o, retire_store_o,
    input  rb_we_o, rb_waddr_o, rb_data_o, recover_o, exc_o, exc_id_o
  );

  modport slave (
    input  alloc_i, alloc_id_i, alloc_we_i, alloc_waddr_i, alloc_old_i, alloc_store_i,
    input  cmpl_valid_i, cmpl_id_i, cmpl_exc_i,
    output full_o, empty_o, retire_valid_o, retire_id_o, retire_store_o,
    output rb_we_o, rb_waddr_o, rb_data_o, recover_o, exc_o, exc_id_o
  );
endinterface

// File: rtl/segre_history_file.sv
// ---------------------------------------------------------------------------
// segre_history_file
// Circular history file: ID allocates entries (carrying the old value of the
// destination register), pipelines mark them complete, the head retires in
// program order. An excepting head triggers a youngest->oldest walk that
// restores old register values, then a one-cycle FLUSH reports the exception.
// Ports:
//   clk_i, rsn_i : clock, asynchronous active-low reset
//   hf           : segre_history_file_if.slave (alloc/cmpl in, status/retire/
//                  rollback/exception out)
// Optional (macro SEGRE_HF_STATS_EN):
//   retire_cnt_o   : 32-bit wrapping count of retirements
//   rollback_cnt_o : 16-bit saturating count of exceptions (FLUSH cycles)
// ---------------------------------------------------------------------------
module segre_history_file #(
  parameter int HF_SIZE   = 16,
  parameter int HF_PTR    = $clog2(HF_SIZE),
  parameter int NUM_CMPL  = 3,
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  segre_history_file_if.slave hf
`ifdef SEGRE_HF_STATS_EN
  ,
  output logic [31:0]         retire_cnt_o,
  output logic [15:0]         rollback_cnt_o
`endif
);

  localparam logic [HF_PTR:0] HF_FULL = (HF_PTR+1)'(HF_SIZE);

  typedef enum logic [1:0] {RUN = 2'd0, ROLLBACK = 2'd1, FLUSH = 2'd2} state_e;

  state_e                 state;
  logic [HF_PTR-1:0]      head, tail, walk, exc_id;
  logic [HF_PTR:0]        count;
  logic [HF_SIZE-1:0]     valid, done, exc;
  logic [HF_SIZE-1:0]     we, store;
  logic [REG_SIZE-1:0]    waddr [HF_SIZE];
  logic [WORD_SIZE-1:0]   old   [HF_SIZE];

  logic                   is_run, is_rb, is_flush, full, empty;
  logic                   alloc_ok, head_ready, retire, trap;
  logic [HF_SIZE-1:0]     cmpl_hit, cmpl_err;

  assign is_run     = (state == RUN);
  assign is_rb      = (state == ROLLBACK);
  assign is_flush   = (state == FLUSH);
  assign full       = (count == HF_FULL);
  assign empty      = (count == '0);
  assign alloc_ok   = is_run && hf.alloc_i && !full;
  assign head_ready = is_run && valid[head] && done[head];
  assign retire     = head_ready && !exc[head];
  assign trap       = head_ready && exc[head];

  // Decode completion ports into per-entry done/exception masks.
  always_comb begin
    cmpl_hit = '0;
    cmpl_err = '0;
    for (int k = 0; k < NUM_CMPL; k++) begin
      if (hf.cmpl_valid_i[k]) begin
        cmpl_hit[hf.cmpl_id_i[k*HF_PTR +: HF_PTR]] = 1'b1;
        cmpl_err[hf.cmpl_id_i[k*HF_PTR +: HF_PTR]] =
          cmpl_err[hf.cmpl_id_i[k*HF_PTR +: HF_PTR]] | hf.cmpl_exc_i[k];
      end else begin
        cmpl_hit = cmpl_hit;
      end
    end
  end

  // Pointers, entry status bits and the RUN/ROLLBACK/FLUSH state machine.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state  <= RUN;
      head   <= '0;
      tail   <= '0;
      walk   <= '0;
      exc_id <= '0;
      count  <= '0;
      valid  <= '0;
      done   <= '0;
      exc    <= '0;
    end else begin
      case (state)
        RUN: begin
          // Completions only land on live entries; a fresh alloc overrides below.
          done <= done | (cmpl_hit & valid);
          exc  <= exc | (cmpl_err & valid);
          if (alloc_ok) begin
            valid[tail] <= 1'b1;
            done[tail]  <= 1'b0;
            exc[tail]   <= 1'b0;
            tail        <= tail + HF_PTR'(1);
          end
          if (retire) begin
            valid[head] <= 1'b0;
            head        <= head + HF_PTR'(1);
          end
          if (alloc_ok && !retire) begin
            count <= count + (HF_PTR+1)'(1);
          end else if (!alloc_ok && retire) begin
            count <= count - (HF_PTR+1)'(1);
          end
          if (trap) begin
            state  <= ROLLBACK;
            exc_id <= head;
            // An entry allocated in the trap cycle is the youngest and must be undone too.
            walk   <= alloc_ok ? tail : tail - HF_PTR'(1);
          end
        end
        ROLLBACK: begin
          valid[walk] <= 1'b0;
          walk        <= walk - HF_PTR'(1);
          if (walk == head) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          // Keep tail where it is so it stays aligned with ID's instr_id counter.
          head  <= tail;
          count <= '0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Entry payload; only read while the owning entry is live.
  always_ff @(posedge clk_i) begin
    if (alloc_ok) begin
      we[tail]    <= hf.alloc_we_i;
      store[tail] <= hf.alloc_store_i;
      waddr[tail] <= hf.alloc_waddr_i;
      old[tail]   <= hf.alloc_old_i;
    end
  end

  assign hf.full_o         = full;
  assign hf.empty_o        = empty;
  assign hf.retire_valid_o = retire;
  assign hf.retire_id_o    = retire ? head : '0;
  assign hf.retire_store_o = retire && store[head];
  assign hf.rb_we_o        = is_rb && we[walk] && (waddr[walk] != '0);
  assign hf.rb_waddr_o     = is_rb ? waddr[walk] : '0;
  assign hf.rb_data_o      = is_rb ? old[walk] : '0;
  assign hf.recover_o      = !is_run;
  assign hf.exc_o          = is_flush;
  assign hf.exc_id_o       = is_flush ? exc_id : '0;

`ifdef SEGRE_HF_STATS_EN
  // Retire (wrapping) and rollback (saturating) statistics.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      retire_cnt_o   <= 32'd0;
      rollback_cnt_o <= 16'd0;
    end else begin
      if (retire) begin
        retire_cnt_o <= retire_cnt_o + 32'd1;
      end
      if (is_flush && (rollback_cnt_o != 16'hFFFF)) begin
        rollback_cnt_o <= rollback_cnt_o + 16'd1;
      end
    end
  end
`endif

  segre_history_file_chk #(.HF_PTR(HF_PTR)) u_chk (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .alloc_i    (hf.alloc_i),
    .alloc_id_i (hf.alloc_id_i),
    .tail       (tail),
    .full       (full),
    .run        (is_run)
  );

endmodule

// ---------------------------------------------------------------------------
// segre_history_file_chk
// Allocation protocol checks: ID's instr_id must match the tail, and an
// allocation while full or recovering is dropped (reported as a warning).
// ---------------------------------------------------------------------------
module segre_history_file_chk #(
  parameter int HF_PTR = 4
) (
  input logic              clk_i,
  input logic              rsn_i,
  input logic              alloc_i,
  input logic [HF_PTR-1:0] alloc_id_i,
  input logic [HF_PTR-1:0] tail,
  input logic              full,
  input logic              run
);
  a_alloc_id: assert property (@(posedge clk_i) disable iff (!rsn_i)
    (alloc_i && !full && run) |-> (alloc_id_i == tail));

  a_alloc_drop: assert property (@(posedge clk_i) disable iff (!rsn_i)
    alloc_i |-> (!full && run))
    else $warning("segre_history_file: allocation dropped (full or recovering)");
endmodule

// File: tb/tb_segre_history_file.sv
module tb_segre_history_file;
  localparam int HF_SIZE = 16, HF_PTR = 4, NUM_CMPL = 3, WORD_SIZE = 32, REG_SIZE = 5;

  logic clk = 1'b0;
  logic rsn = 1'b1;
  always #5 clk = ~clk;

  segre_history_file_if #(.HF_PTR(HF_PTR), .NUM_CMPL(NUM_CMPL), .WORD_SIZE(WORD_SIZE),
                          .REG_SIZE(REG_SIZE)) hf ();
`ifdef SEGRE_HF_STATS_EN
  logic [31:0] retire_cnt;
  logic [15:0] rollback_cnt;
`endif

  segre_history_file #(.HF_SIZE(HF_SIZE), .HF_PTR(HF_PTR), .NUM_CMPL(NUM_CMPL),
                       .WORD_SIZE(WORD_SIZE), .REG_SIZE(REG_SIZE)) dut (
    .clk_i(clk), .rsn_i(rsn), .hf(hf)
`ifdef SEGRE_HF_STATS_EN
    , .retire_cnt_o(retire_cnt), .rollback_cnt_o(rollback_cnt)
`endif
  );

  typedef struct {
    logic [3:0] id; logic we; logic [4:0] waddr; logic [31:0] old;
    logic store; logic done; logic exc;
  } ent_t;

  // Behavioural model: program-ordered list of live entries, pending restores, flush flag.
  ent_t q[$];
  ent_t rb_q[$];
  int cnt, n_ret, n_flush, cyc;
  logic [3:0] tail_id, exc_id_m;
  logic flush_p;
  int checks = 0, errors = 0;

  int ret_log[$], ret_cyc[$], exc_log[$];
  logic [37:0] rb_log[$];
  int rec_n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete(); rb_q.delete();
    cnt = 0; n_ret = 0; n_flush = 0; tail_id = 4'd0; exc_id_m = 4'd0; flush_p = 1'b0;
  endtask

  task automatic model_step();
    logic trap, ret;
    logic [3:0] cid;
    if (rb_q.size() > 0) begin
      void'(rb_q.pop_front());
      if (rb_q.size() == 0) flush_p = 1'b1;
    end else if (flush_p) begin
      flush_p = 1'b0; cnt = 0; n_flush++;
    end else begin
      trap = (q.size() > 0) && q[0].done && q[0].exc;
      ret  = (q.size() > 0) && q[0].done && !q[0].exc;
      for (int k = 0; k < NUM_CMPL; k++) begin
        if (hf.cmpl_valid_i[k]) begin
          cid = hf.cmpl_id_i[k*HF_PTR +: HF_PTR];
          for (int i = 0; i < q.size(); i++)
            if (q[i].id == cid) begin
              q[i].done = 1'b1;
              q[i].exc  = q[i].exc | hf.cmpl_exc_i[k];
            end
        end
      end
      if (hf.alloc_i && cnt < HF_SIZE) begin
        q.push_back('{tail_id, hf.alloc_we_i, hf.alloc_waddr_i, hf.alloc_old_i,
                      hf.alloc_store_i, 1'b0, 1'b0});
        tail_id = tail_id + 4'd1; cnt++;
      end
      if (ret) begin void'(q.pop_front()); cnt--; n_ret++; end
      if (trap) begin
        exc_id_m = q[0].id;
        for (int i = q.size() - 1; i >= 0; i--) rb_q.push_back(q[i]);
        q.delete();
      end
    end
  endtask

  // One clock: compare all outputs against the model, take the edge, advance the model.
  task automatic cycle();
    logic e_ret, e_rst, e_rbwe, e_rec, e_exc;
    logic [3:0] e_rid, e_eid;
    logic [4:0] e_rba;
    logic [31:0] e_rbd;
    e_ret = 0; e_rst = 0; e_rbwe = 0; e_rec = 0; e_exc = 0;
    e_rid = 0; e_eid = 0; e_rba = 0; e_rbd = 0;
    if (rb_q.size() > 0) begin
      e_rec = 1; e_rbwe = rb_q[0].we && (rb_q[0].waddr != 5'd0);
      e_rba = rb_q[0].waddr; e_rbd = rb_q[0].old;
    end else if (flush_p) begin
      e_rec = 1; e_exc = 1; e_eid = exc_id_m;
    end else if (q.size() > 0 && q[0].done && !q[0].exc) begin
      e_ret = 1; e_rid = q[0].id; e_rst = q[0].store;
    end
    chk("full", hf.full_o, cnt == HF_SIZE);
    chk("empty", hf.empty_o, cnt == 0);
    chk("retire_valid", hf.retire_valid_o, e_ret);
    chk("retire_id", hf.retire_id_o, e_rid);
    chk("retire_store", hf.retire_store_o, e_rst);
    chk("rb_we", hf.rb_we_o, e_rbwe);
    chk("rb_waddr", hf.rb_waddr_o, e_rba);
    chk("rb_data", hf.rb_data_o, e_rbd);
    chk("recover", hf.recover_o, e_rec);
    chk("exc", hf.exc_o, e_exc);
    chk("exc_id", hf.exc_id_o, e_eid);
`ifdef SEGRE_HF_STATS_EN
    chk("retire_cnt", retire_cnt, n_ret);
    chk("rollback_cnt", rollback_cnt, n_flush);
`endif
    if (hf.retire_valid_o) begin ret_log.push_back(int'(hf.retire_id_o)); ret_cyc.push_back(cyc); end
    if (hf.recover_o) rec_n++;
    if (hf.recover_o && !hf.exc_o) rb_log.push_back({hf.rb_we_o, hf.rb_waddr_o, hf.rb_data_o});
    if (hf.exc_o) exc_log.push_back(int'(hf.exc_id_o));
    @(posedge clk);
    if (!rsn) model_reset(); else model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    hf.alloc_i = 0; hf.alloc_id_i = 0; hf.alloc_we_i = 0; hf.alloc_waddr_i = 0;
    hf.alloc_old_i = 0; hf.alloc_store_i = 0;
    hf.cmpl_valid_i = 0; hf.cmpl_id_i = 0; hf.cmpl_exc_i = 0;
  endtask

  task automatic drive_alloc(input logic w, input logic [4:0] a, input logic [31:0] o, input logic s);
    hf.alloc_i = 1; hf.alloc_id_i = tail_id; hf.alloc_we_i = w;
    hf.alloc_waddr_i = a; hf.alloc_old_i = o; hf.alloc_store_i = s;
  endtask

  task automatic drive_cmpl(input int k, input logic [3:0] id, input logic e);
    hf.cmpl_valid_i[k] = 1'b1; hf.cmpl_id_i[k*HF_PTR +: HF_PTR] = id; hf.cmpl_exc_i[k] = e;
  endtask

  task automatic clr_logs();
    ret_log.delete(); ret_cyc.delete(); exc_log.delete(); rb_log.delete(); rec_n = 0;
  endtask

  task automatic do_reset();
    idle(); rsn = 0; model_reset();
    cycle(); cycle();
    rsn = 1; clr_logs();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && !(cnt == 0 && rb_q.size() == 0 && !flush_p); i++) begin
      idle();
      for (int k = 0; k < NUM_CMPL && k < q.size(); k++) drive_cmpl(k, q[k].id, 1'b0);
      cycle();
    end
    idle();
    chk("drain_empty", hf.empty_o, 1);
  endtask

  task automatic rand_drive();
    logic ok;
    ok = (rb_q.size() == 0) && !flush_p && (cnt < HF_SIZE);
    idle();
    if ((ok && $urandom_range(0, 99) < 60) || (!ok && $urandom_range(0, 99) < 2))
      drive_alloc(1'($urandom), 5'($urandom), $urandom, 1'($urandom));
    for (int k = 0; k < NUM_CMPL; k++)
      if ($urandom_range(0, 99) < 35) begin
        if (q.size() > 0 && $urandom_range(0, 99) < 85)
          drive_cmpl(k, q[$urandom_range(0, q.size() - 1)].id, $urandom_range(0, 99) < 4);
        else
          drive_cmpl(k, 4'($urandom), $urandom_range(0, 99) < 4);
      end
  endtask

  int c0;

  initial begin
    idle(); model_reset(); cyc = 0; clr_logs();
    #1 rsn = 0;
    @(negedge clk);
    chk("rst_empty", hf.empty_o, 1);
    chk("rst_full", hf.full_o, 0);
    chk("rst_retire", hf.retire_valid_o, 0);
    chk("rst_recover", hf.recover_o, 0);
    cycle(); rsn = 1; clr_logs();

    // Out-of-order completion, in-order retirement.
    do_reset();
    for (int i = 0; i < 4; i++) begin drive_alloc(1, 5'(5 + i), 32'(i), 0); cycle(); end
    idle(); cycle();
    idle(); drive_cmpl(1, 4'd2, 0); cycle();
    idle(); drive_cmpl(1, 4'd0, 0); c0 = cyc; cycle();
    idle(); drive_cmpl(1, 4'd3, 0); cycle();
    idle(); drive_cmpl(1, 4'd1, 0); cycle();
    idle(); repeat (6) cycle();
    chk("t1_nret", ret_log.size(), 4);
    if (ret_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t1_order", ret_log[i], i);
      chk("t1_first_lat", ret_cyc[0], c0 + 1);
      chk("t1_b2b_2", ret_cyc[2], ret_cyc[1] + 1);
      chk("t1_b2b_3", ret_cyc[3], ret_cyc[2] + 1);
    end

    // Fill to 16, dropped 17th, then free one slot.
    do_reset();
    for (int i = 0; i < 16; i++) begin drive_alloc(1, 5'(i), $urandom, 0); cycle(); end
    idle();
    chk("t2_full16", hf.full_o, 1);
    drive_alloc(1, 5'd1, 32'hDEAD, 0); cycle(); idle();
    chk("t2_full17", hf.full_o, 1);
    drive_cmpl(0, 4'd0, 0); cycle(); idle();
    chk("t2_ret_valid", hf.retire_valid_o, 1);
    chk("t2_ret_id", hf.retire_id_o, 0);
    chk("t2_full_at_retire", hf.full_o, 1);
    cycle();
    chk("t2_full_after", hf.full_o, 0);
    drain();

    // Rollback of three entries with an x0 destination in the middle.
    do_reset();
    drive_alloc(1, 5'd5, 32'h11, 0); cycle();
    drive_alloc(1, 5'd0, 32'h0, 0); cycle();
    drive_alloc(1, 5'd7, 32'h33, 0); cycle();
    idle(); drive_cmpl(0, 4'd0, 1); cycle();
    idle(); repeat (8) cycle();
    chk("t3_nrb", rb_log.size(), 3);
    if (rb_log.size() == 3) begin
      chk("t3_rb0", rb_log[0], {1'b1, 5'd7, 32'h33});
      chk("t3_rb1", rb_log[1], {1'b0, 5'd0, 32'h0});
      chk("t3_rb2", rb_log[2], {1'b1, 5'd5, 32'h11});
    end
    chk("t3_recover_cycles", rec_n, 4);
    chk("t3_nexc", exc_log.size(), 1);
    if (exc_log.size() == 1) chk("t3_exc_id", exc_log[0], 0);
    chk("t3_empty", hf.empty_o, 1);

    // Wrap: 20 alloc/retire pairs.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      idle();
      if (i < 20) drive_alloc(1, 5'(i), 32'(i), 1'(i));
      if (i >= 1 && i <= 20) drive_cmpl(0, 4'(i - 1), 0);
      cycle();
    end
    idle(); repeat (4) cycle();
    chk("t4_nret", ret_log.size(), 20);
    if (ret_log.size() == 20)
      for (int i = 0; i < 20; i++) chk("t4_order", ret_log[i], i % 16);

    // Two ports completing different entries in one cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin drive_alloc(1, 5'(i + 1), 32'(i), 0); cycle(); end
    for (int i = 0; i < 4; i++) begin idle(); drive_cmpl(1, 4'(i), 0); cycle(); end
    idle(); drive_cmpl(0, 4'd4, 0); drive_cmpl(2, 4'd5, 0); cycle();
    idle(); repeat (6) cycle();
    chk("t5_nret", ret_log.size(), 6);
    if (ret_log.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t5_order", ret_log[i], i);
      chk("t5_b2b", ret_cyc[5], ret_cyc[4] + 1);
    end

    // Reset in the middle of a rollback walk.
    do_reset();
    for (int i = 0; i < 5; i++) begin drive_alloc(1, 5'(i + 3), 32'(i + 100), 0); cycle(); end
    idle(); drive_cmpl(2, 4'd0, 1); cycle(); idle();
    for (int i = 0; i < 20 && !hf.recover_o; i++) cycle();
    chk("t6_rollback_start", hf.recover_o, 1);
    cycle();
    #2 rsn = 0;
    #1;
    chk("t6_rst_rb_we", hf.rb_we_o, 0);
    chk("t6_rst_rb_waddr", hf.rb_waddr_o, 0);
    chk("t6_rst_rb_data", hf.rb_data_o, 0);
    chk("t6_rst_recover", hf.recover_o, 0);
    chk("t6_rst_exc", hf.exc_o, 0);
    chk("t6_rst_retire", hf.retire_valid_o, 0);
    model_reset();
    @(negedge clk);
    cycle();
    rsn = 1; clr_logs();
    cycle();
    chk("t6_empty", hf.empty_o, 1);
    drive_alloc(1, 5'd9, 32'h99, 1); cycle();
    idle(); drive_cmpl(0, 4'd0, 0); cycle(); idle();
    chk("t6_ret_valid", hf.retire_valid_o, 1);
    chk("t6_ret_id_head0", hf.retire_id_o, 0);
    cycle();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin rand_drive(); cycle(); end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
